// File: rtl/mc_request_queue.sv
// mc_request_queue: captures {time,cmd,addr} trace words into an in-order FIFO and issues the head once cycle reaches its timestamp.
// Optional MCQ_TRACE_EN prints capture/pop/drop/bad_cmd events; undefined by default.
module mc_request_queue #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 36,
  parameter int CMD_WIDTH  = 12,
  parameter int TIME_WIDTH = 12,
  parameter int CYC_WIDTH  = 64
) (
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic [CYC_WIDTH-1:0]                      cycle,
  input  logic                                      data_rdy,
  input  logic [TIME_WIDTH+CMD_WIDTH+ADDR_WIDTH-1:0] data_read,
  input  logic                                      shutdown,
  output logic                                      data_req,
  output logic                                      issue_valid,
  input  logic                                      issue_ready,
  output logic [1:0]                                issue_cmd,
  output logic [ADDR_WIDTH-1:0]                     issue_addr,
  output logic [$clog2(DEPTH):0]                    q_count,
  output logic                                      overflow,
  output logic                                      bad_cmd,
  output logic                                      done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} state_t;
  state_t r_state, w_next;
  logic r_rdy_q, r_data_req, r_overflow, r_bad_cmd;
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count, w_count_next;
  logic [TIME_WIDTH-1:0] r_time [DEPTH];
  logic [1:0] r_cmd [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [CMD_WIDTH-1:0] w_cmd;
  logic [TIME_WIDTH-1:0] w_time;
  logic w_capture, w_bad, w_empty, w_full, w_pop, w_accept, w_drop;
  assign w_addr = data_read[ADDR_WIDTH-1:0];
  assign w_cmd = data_read[ADDR_WIDTH +: CMD_WIDTH];
  assign w_time = data_read[ADDR_WIDTH+CMD_WIDTH +: TIME_WIDTH];
  assign w_capture = data_rdy && !r_rdy_q;
  assign w_bad = w_cmd > CMD_WIDTH'(2);
  assign w_empty = r_count == '0;
  assign w_full = r_count == L_DEPTH;
  // Timestamp is zero-extended; the head blocks everything behind it.
  assign issue_valid = !w_empty && (cycle >= CYC_WIDTH'(r_time[r_rd]));
  assign w_pop = issue_valid && issue_ready;
  // A same-edge pop frees the slot, so a capture into a full queue still lands.
  assign w_accept = w_capture && !w_bad && (!w_full || w_pop);
  assign w_drop = w_capture && !w_bad && w_full && !w_pop;
  assign w_count_next = r_count + (AW+1)'(w_accept) - (AW+1)'(w_pop);
  assign issue_cmd = w_empty ? 2'd0 : r_cmd[r_rd];
  assign issue_addr = w_empty ? '0 : r_addr[r_rd];
  assign q_count = r_count;
  assign data_req = r_data_req;
  assign overflow = r_overflow;
  assign bad_cmd = r_bad_cmd;
  assign done = (r_state == ST_DRAIN) && w_empty && !w_capture;
  always_comb begin
    w_next = r_state;
    if (shutdown) w_next = ST_DRAIN;
    else
      unique case (r_state)
        ST_IDLE:  w_next = ST_REQ;
        ST_REQ:   w_next = w_capture ? ST_WAIT : ST_REQ;
        ST_WAIT:  w_next = (r_rdy_q && !data_rdy) ? ST_REQ : ST_WAIT;
        ST_DRAIN: w_next = ST_DRAIN;
      endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rdy_q    <= 1'b0;
      r_data_req <= 1'b0;
      r_overflow <= 1'b0;
      r_bad_cmd  <= 1'b0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_rdy_q    <= data_rdy;
      r_data_req <= (w_next == ST_REQ) && !shutdown && (w_count_next < L_DEPTH);
      r_overflow <= r_overflow || w_drop;
      r_bad_cmd  <= r_bad_cmd || (w_capture && w_bad);
      r_wr       <= w_accept ? r_wr + 1'b1 : r_wr;
      r_rd       <= w_pop ? r_rd + 1'b1 : r_rd;
      r_count    <= w_count_next;
    end
  end
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_time[r_wr] <= w_time;
      r_cmd[r_wr]  <= w_cmd[1:0];
      r_addr[r_wr] <= w_addr;
    end
  end
`ifdef MCQ_TRACE_EN
  always @(posedge clock) begin
    if (reset_n) begin
      if (w_accept) $display($time, " [MC] CYCLE: %0d CAPTURE cmd %0d addr %x", cycle, w_cmd, w_addr);
      if (w_pop) $display($time, " [MC] CYCLE: %0d POP cmd %0d addr %x", cycle, issue_cmd, issue_addr);
      if (w_drop) $display($time, " [MC] CYCLE: %0d DROP cmd %0d addr %x", cycle, w_cmd, w_addr);
      if (w_capture && w_bad) $display($time, " [MC] CYCLE: %0d BAD_CMD cmd %0d addr %x", cycle, w_cmd, w_addr);
    end
  end
`else
`endif
endmodule

// File: tb/tb_mc_request_queue.sv
// tb_mc_request_queue: directed stimulus with a queue-based reference model compared every cycle.
module tb_mc_request_queue;
  localparam int DEPTH = 16;
  typedef struct { logic [11:0] t; logic [1:0] c; logic [35:0] a; } ent_t;
  logic clk, rst_n, data_rdy, shutdown, issue_ready;
  logic [63:0] cyc;
  logic [59:0] data_read;
  logic data_req, issue_valid, overflow, bad_cmd, done;
  logic [1:0] issue_cmd;
  logic [35:0] issue_addr;
  logic [4:0] q_count;
  int checks = 0, errors = 0;
  ent_t m_q[$];
  logic m_rdy_q, m_ovf, m_bad, m_drain;

  mc_request_queue dut (
    .clock(clk), .reset_n(rst_n), .cycle(cyc), .data_rdy(data_rdy), .data_read(data_read),
    .shutdown(shutdown), .data_req(data_req), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_cmd(issue_cmd), .issue_addr(issue_addr), .q_count(q_count), .overflow(overflow),
    .bad_cmd(bad_cmd), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic m_valid();
    return m_q.size() > 0 && cyc >= 64'(m_q[0].t);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_rdy_q <= 1'b0;
      m_ovf   <= 1'b0;
      m_bad   <= 1'b0;
      m_drain <= 1'b0;
    end else begin
      m_rdy_q <= data_rdy;
      if (shutdown) m_drain <= 1'b1;
      if (m_valid() && issue_ready) void'(m_q.pop_front());
      if (data_rdy && !m_rdy_q) begin
        if (data_read[47:36] > 12'd2) m_bad <= 1'b1;
        else if (m_q.size() == DEPTH) m_ovf <= 1'b1;
        else m_q.push_back('{data_read[59:48], data_read[37:36], data_read[35:0]});
      end
    end
  end

  always @(negedge clk) begin
    chk("q_count", 64'(q_count), 64'(m_q.size()));
    chk("issue_valid", 64'(issue_valid), 64'(m_valid()));
    chk("issue_cmd", 64'(issue_cmd), m_q.size() > 0 ? 64'(m_q[0].c) : 64'd0);
    chk("issue_addr", 64'(issue_addr), m_q.size() > 0 ? 64'(m_q[0].a) : 64'd0);
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("bad_cmd", 64'(bad_cmd), 64'(m_bad));
    chk("done", 64'(done), 64'(m_drain && m_q.size() == 0 && !(data_rdy && !m_rdy_q)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!data_req && n < 20) begin
      tick();
      n++;
    end
    chk("wait_req", 64'(data_req), 64'd1);
  endtask

  task automatic send(input logic [59:0] w, input int len);
    data_read = w;
    data_rdy = 1'b1;
    repeat (len) tick();
    data_rdy = 1'b0;
    tick();
  endtask

  task automatic fill(input int n, input logic [11:0] t0, input logic [11:0] t);
    for (int i = 0; i < n; i++) begin
      wait_req();
      send({(i == 0) ? t0 : t, 12'(i % 3), 36'h100 + 36'(i)}, 1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; data_rdy = 1'b0; shutdown = 1'b0; issue_ready = 1'b0; cyc = '0; data_read = '0;
    tick();
    tick();
    chk("rst_data_req", 64'(data_req), 64'd0);
    chk("rst_count", 64'(q_count), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("t1_req_up", 64'(data_req), 64'd1);
    // T1: capture at cycle 2, due at cycle 5
    cyc = 64'd2;
    data_read = {12'd5, 12'd0, 36'h1234};
    data_rdy = 1'b1;
    tick();
    data_rdy = 1'b0;
    chk("t1_count", 64'(q_count), 64'd1);
    chk("t1_req_wait", 64'(data_req), 64'd0);
    chk("t1_valid_c2", 64'(issue_valid), 64'd0);
    tick();
    cyc = 64'd3; tick();
    chk("t1_valid_c3", 64'(issue_valid), 64'd0);
    cyc = 64'd4; tick();
    chk("t1_valid_c4", 64'(issue_valid), 64'd0);
    cyc = 64'd5; #1;
    chk("t1_valid_c5", 64'(issue_valid), 64'd1);
    chk("t1_cmd", 64'(issue_cmd), 64'd0);
    chk("t1_addr", 64'(issue_addr), 64'h1234);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("t1_pop", 64'(q_count), 64'd0);
    // T2: one capture for a three-clock pulse
    wait_req();
    data_read = {12'd0, 12'd1, 36'hAA};
    data_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_count", 64'(q_count), 64'd1);
      chk("t2_req_low", 64'(data_req), 64'd0);
    end
    data_rdy = 1'b0;
    tick();
    chk("t2_req_back", 64'(data_req), 64'd1);
    chk("t2_count_end", 64'(q_count), 64'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_req", 64'(data_req), 64'd0);
    chk("mid_rst_count", 64'(q_count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // T3: fill, then a forced 17th word overflows
    fill(DEPTH, 12'd4095, 12'd4095);
    chk("t3_full", 64'(q_count), 64'd16);
    chk("t3_req_full", 64'(data_req), 64'd0);
    tick();
    chk("t3_req_full2", 64'(data_req), 64'd0);
    send({12'd4095, 12'd0, 36'h999}, 1);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_count", 64'(q_count), 64'd16);
    do_reset();
    chk("t3_rst_ovf", 64'(overflow), 64'd0);
    // T4: capture and pop on the same edge while full
    fill(DEPTH, 12'd0, 12'd4095);
    chk("t4_head", 64'(issue_addr), 64'h100);
    data_read = {12'd0, 12'd2, 36'hBEEF};
    data_rdy = 1'b1;
    issue_ready = 1'b1;
    tick();
    data_rdy = 1'b0;
    issue_ready = 1'b0;
    chk("t4_count", 64'(q_count), 64'd16);
    chk("t4_ovf", 64'(overflow), 64'd0);
    chk("t4_head2", 64'(issue_addr), 64'h101);
    cyc = 64'd4095;
    issue_ready = 1'b1;
    repeat (15) tick();
    chk("t4_last", 64'(issue_addr), 64'hBEEF);
    chk("t4_last_cmd", 64'(issue_cmd), 64'd2);
    tick();
    issue_ready = 1'b0;
    chk("t4_empty", 64'(q_count), 64'd0);
    // T5: illegal command is discarded
    wait_req();
    send({12'd0, 12'd7, 36'h777}, 1);
    chk("t5_bad", 64'(bad_cmd), 64'd1);
    chk("t5_count", 64'(q_count), 64'd0);
    wait_req();
    send({12'd0, 12'd1, 36'h555}, 1);
    chk("t5_next", 64'(q_count), 64'd1);
    chk("t5_cmd", 64'(issue_cmd), 64'd1);
    chk("t5_addr", 64'(issue_addr), 64'h555);
    // T6: shutdown drains two due entries
    wait_req();
    send({12'd10, 12'd2, 36'h666}, 1);
    chk("t6_count", 64'(q_count), 64'd2);
    shutdown = 1'b1;
    tick();
    chk("t6_req", 64'(data_req), 64'd0);
    chk("t6_not_done", 64'(done), 64'd0);
    issue_ready = 1'b1;
    tick();
    chk("t6_pop1", 64'(q_count), 64'd1);
    chk("t6_addr", 64'(issue_addr), 64'h666);
    tick();
    issue_ready = 1'b0;
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_bad_hold", 64'(bad_cmd), 64'd1);
    rst_n = 1'b0; #1;
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_bad", 64'(bad_cmd), 64'd0);
    chk("t6_rst_req", 64'(data_req), 64'd0);
    shutdown = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
